// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: 2-FF sync, bounce filter, and
// press/release/long-press strobes with a wrapping per-channel press counter.
module key_debounce_multi #(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 100000000,
    parameter int CNT_W       = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         key,
    output logic [N_KEYS-1:0]         key_state,
    output logic [N_KEYS-1:0]         press_pulse,
    output logic [N_KEYS-1:0]         release_pulse,
    output logic [N_KEYS-1:0]         long_pulse,
    output logic [N_KEYS*CNT_W-1:0]   press_cnt
);

    localparam int MAXC   = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
    localparam int STAB_W = $clog2(MAXC + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PWAIT   = 2'd1;
    localparam logic [1:0] S_PRESSED = 2'd2;
    localparam logic [1:0] S_RWAIT   = 2'd3;

    localparam logic [STAB_W-1:0] DEB_LAST = STAB_W'(DEB_CYCLES - 1);
    localparam logic [STAB_W-1:0] LONG_MAX = STAB_W'(LONG_CYCLES);
    localparam logic [STAB_W-1:0] LONG_PRE = STAB_W'(LONG_CYCLES - 1);
    localparam logic [STAB_W-1:0] ONE      = STAB_W'(1);
    localparam logic              REL_LVL  = (ACTIVE_LOW != 0);

    genvar g;
    generate
        for (g = 0; g < N_KEYS; g++) begin : g_ch
            logic              r_sync1;
            logic              r_sync2;
            logic [1:0]        r_state;
            logic [STAB_W-1:0] r_stab;
            logic              r_key_state;
            logic              r_press;
            logic              r_release;
            logic              r_long;
            logic [CNT_W-1:0]  r_cnt;
            logic              w_p;

            // Normalised level: 1 means pressed regardless of pin polarity.
            assign w_p = r_sync2 ^ REL_LVL;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_sync1     <= REL_LVL;
                    r_sync2     <= REL_LVL;
                    r_state     <= S_IDLE;
                    r_stab      <= '0;
                    r_key_state <= 1'b0;
                    r_press     <= 1'b0;
                    r_release   <= 1'b0;
                    r_long      <= 1'b0;
                    r_cnt       <= '0;
                end else begin
                    r_sync1   <= key[g];
                    r_sync2   <= r_sync1;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;
                    case (r_state)
                        S_IDLE: begin
                            if (w_p) begin
                                r_state <= S_PWAIT;
                                r_stab  <= ONE;
                            end
                        end
                        S_PWAIT: begin
                            if (!w_p) begin
                                r_state <= S_IDLE;
                                r_stab  <= '0;
                            end else if (r_stab == DEB_LAST) begin
                                r_state     <= S_PRESSED;
                                r_stab      <= '0;
                                r_press     <= 1'b1;
                                r_key_state <= 1'b1;
                                r_cnt       <= r_cnt + CNT_W'(1);
                            end else begin
                                r_stab <= r_stab + ONE;
                            end
                        end
                        S_PRESSED: begin
                            if (!w_p) begin
                                r_state <= S_RWAIT;
                                r_stab  <= ONE;
                            end else if (r_stab != LONG_MAX) begin
                                r_stab <= r_stab + ONE;
                                if (r_stab == LONG_PRE)
                                    r_long <= 1'b1;
                            end
                        end
                        S_RWAIT: begin
                            // Returning to PRESSED saturated keeps long-press disarmed.
                            if (w_p) begin
                                r_state <= S_PRESSED;
                                r_stab  <= LONG_MAX;
                            end else if (r_stab == DEB_LAST) begin
                                r_state     <= S_IDLE;
                                r_stab      <= '0;
                                r_release   <= 1'b1;
                                r_key_state <= 1'b0;
                            end else begin
                                r_stab <= r_stab + ONE;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_stab  <= '0;
                        end
                    endcase
                end
            end

            assign key_state[g]                 = r_key_state;
            assign press_pulse[g]               = r_press;
            assign release_pulse[g]             = r_release;
            assign long_pulse[g]                = r_long;
            assign press_cnt[g*CNT_W +: CNT_W]  = r_cnt;
        end
    endgenerate

endmodule
